// File: rtl/lenet_pkg.sv
// lenet_pkg: shared definitions for the MAC array.
//   mode_e  - activation routing: broadcast group 0, or lane i takes group i mod G
//   GUARD_W - extra accumulator bits above the per-lane result width
package lenet_pkg;

  typedef enum logic {
    MODE_BCAST = 1'b0,
    MODE_GROUP = 1'b1
  } mode_e;

  localparam int unsigned GUARD_W = 4;

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one MAC lane. Stage 1 registers the product, stage 2 accumulates.
// Optional saturation is enabled by defining MAC_BANK_SAT_EN.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - accepted beat: capture product and enable into stage 1
//   a, b      - signed activation / weight for this lane
//   en        - lane enable for the sum the beat belongs to
//   acc_en    - stage 1 holds a valid beat: update the accumulator
//   first     - stage 1 beat starts a new sum (load instead of add)
//   result    - saturated or wrapped accumulator value
//   ovf       - lane clipped (saturation build only)
module mac_lane
  import lenet_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 8,
  parameter int ACC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic                    en,
  input  logic                    acc_en,
  input  logic                    first,
  output logic        [ACC_W-1:0] result,
  output logic                    ovf
);

  localparam int P_W   = A_W + B_W;
  localparam int ACC_X = ACC_W + int'(GUARD_W);

  logic signed [P_W-1:0]   a_x, b_x, prod;
  logic signed [P_W-1:0]   prod_q;
  logic                    en_q;
  logic signed [ACC_X-1:0] acc;
  logic signed [ACC_X-1:0] prod_ext;

  always_comb begin
    a_x  = P_W'(a);
    b_x  = P_W'(b);
    prod = a_x * b_x;
    prod_ext = ACC_X'(prod_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      en_q   <= 1'b0;
    end else if (load) begin
      prod_q <= en ? prod : '0;
      en_q   <= en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_en) begin
      if (!en_q)      acc <= '0;
      else if (first) acc <= prod_ext;
      else            acc <= acc + prod_ext;
    end
  end

`ifdef MAC_BANK_SAT_EN
  // Value fits in ACC_W bits iff the guard bits and the result sign bit agree.
  logic [GUARD_W:0] top_bits;
  logic             clip;

  always_comb begin
    top_bits = acc[ACC_X-1:ACC_W-1];
    clip     = ~((&top_bits) | ~(|top_bits));
    ovf      = clip;
    if (clip) result = acc[ACC_X-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else      result = acc[ACC_W-1:0];
  end
`else
  logic unused_guard;

  always_comb begin
    result       = acc[ACC_W-1:0];
    ovf          = 1'b0;
    unused_guard = ^acc[ACC_X-1:ACC_W];
  end
`endif

endmodule

// File: rtl/shared_mac_array.sv
// shared_mac_array: N_LANE signed MAC lanes sharing a G-group activation bus.
// Optional per-lane saturation is enabled by defining MAC_BANK_SAT_EN.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   mode                - 0 broadcast a_data group 0, 1 lane i uses group i mod G
//   in_valid/in_ready   - input beat handshake; in_first/in_last delimit a sum
//   a_data, b_data      - activations (G groups), weights (one per lane)
//   lane_en             - per-lane enable, sampled on the first beat
//   out_valid/out_ready - result handshake; out_data/out_ovf held until taken
module shared_mac_array
  import lenet_pkg::*;
#(
  parameter int N_LANE = 214,
  parameter int A_W    = 16,
  parameter int B_W    = 8,
  parameter int ACC_W  = 23,
  parameter int G      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [G*A_W-1:0]          a_data,
  input  logic [N_LANE*B_W-1:0]     b_data,
  input  logic [N_LANE-1:0]         lane_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANE*ACC_W-1:0]   out_data,
  output logic                      out_ovf
);

  logic              pend;
  logic              open_sum;
  logic              fire;
  logic              first_eff;
  logic              s1_valid, s1_first, s1_last;
  mode_e             mode_q, mode_eff;
  logic [N_LANE-1:0] lane_en_q, lane_en_eff;
  logic [N_LANE-1:0] lane_ovf;

  assign in_ready  = ~pend;
  assign fire      = in_valid & in_ready;
  // A beat arriving with no sum open starts one even without in_first.
  assign first_eff = in_first | ~open_sum;

  always_comb begin
    mode_eff    = first_eff ? mode_e'(mode) : mode_q;
    lane_en_eff = first_eff ? lane_en : lane_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      open_sum  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      mode_q    <= MODE_BCAST;
      lane_en_q <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= fire;
      s1_first <= first_eff;
      s1_last  <= in_last;
      if (fire) begin
        open_sum <= ~in_last;
        if (first_eff) begin
          mode_q    <= mode_e'(mode);
          lane_en_q <= lane_en;
        end
      end
      if (fire && in_last)           pend <= 1'b1;
      else if (out_valid && out_ready) pend <= 1'b0;
      if (s1_valid && s1_last)       out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    logic [A_W-1:0] a_sel;

    always_comb begin
      a_sel = (mode_eff == MODE_GROUP) ? a_data[(i % G)*A_W +: A_W] : a_data[0 +: A_W];
    end

    mac_lane #(
      .A_W  (A_W),
      .B_W  (B_W),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (fire),
      .a     (a_sel),
      .b     (b_data[i*B_W +: B_W]),
      .en    (lane_en_eff[i]),
      .acc_en(s1_valid),
      .first (s1_first),
      .result(out_data[i*ACC_W +: ACC_W]),
      .ovf   (lane_ovf[i])
    );
  end

  assign out_ovf = |lane_ovf;

endmodule

// File: tb/tb_shared_mac_array.sv
module tb_shared_mac_array;

  localparam int N_LANE = 214;
  localparam int A_W    = 16;
  localparam int B_W    = 8;
  localparam int ACC_W  = 23;
  localparam int G      = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic                    in_last;
  logic [G*A_W-1:0]        a_data;
  logic [N_LANE*B_W-1:0]   b_data;
  logic [N_LANE-1:0]       lane_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_LANE*ACC_W-1:0] out_data;
  logic                    out_ovf;

  int checks   = 0;
  int failures = 0;

  // reference model state: mathematical per-lane sums
  longint m_acc [N_LANE];
  bit     m_en  [N_LANE];
  bit     m_mode;
  bit     m_open;

  logic [N_LANE*ACC_W-1:0] snap;

  always #5 clk = ~clk;

  shared_mac_array #(
    .N_LANE(N_LANE), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .G(G)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a_data(a_data), .b_data(b_data),
    .lane_en(lane_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_clip(input longint s);
`ifdef MAC_BANK_SAT_EN
    longint hi = (longint'(1) << (ACC_W-1)) - 1;
    longint lo = -(longint'(1) << (ACC_W-1));
    return (s > hi) || (s < lo);
`else
    return (s != s + 0) && 1'b0;
`endif
  endfunction

  function automatic logic [ACC_W-1:0] ref_val(input longint s);
    longint hi = (longint'(1) << (ACC_W-1)) - 1;
    longint lo = -(longint'(1) << (ACC_W-1));
    longint v  = s;
`ifdef MAC_BANK_SAT_EN
    if (s > hi) v = hi;
    if (s < lo) v = lo;
`else
    if (hi < lo) v = 0;
`endif
    return v[ACC_W-1:0];
  endfunction

  task automatic model_accept(input bit first, input bit last);
    bit f = first || !m_open;
    if (f) begin
      m_mode = mode;
      for (int i = 0; i < N_LANE; i++) m_en[i] = lane_en[i];
    end
    for (int i = 0; i < N_LANE; i++) begin
      longint av, bv, p;
      int grp = m_mode ? (i % G) : 0;
      av = longint'($signed(a_data[grp*A_W +: A_W]));
      bv = longint'($signed(b_data[i*B_W +: B_W]));
      p  = av * bv;
      if (!m_en[i]) m_acc[i] = 0;
      else if (f)   m_acc[i] = p;
      else          m_acc[i] = m_acc[i] + p;
    end
    m_open = !last;
  endtask

  task automatic send(input bit first, input bit last);
    int n = 0;
    in_valid = 1'b1; in_first = first; in_last = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    model_accept(first, last);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic fill(input int av, input int bv);
    for (int k = 0; k < G; k++)      a_data[k*A_W +: A_W] = A_W'(av);
    for (int i = 0; i < N_LANE; i++) b_data[i*B_W +: B_W] = B_W'(bv);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < G; k++)      a_data[k*A_W +: A_W] = A_W'($urandom);
    for (int i = 0; i < N_LANE; i++) b_data[i*B_W +: B_W] = B_W'($urandom);
  endtask

  // called right after the last beat's accept edge (cycle T+1)
  task automatic expect_result(input string tag);
    bit any_clip = 1'b0;
    chk({tag, "_valid_t1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_t2"}, 64'(out_valid), 64'd1);
    for (int i = 0; i < N_LANE; i++) begin
      chk($sformatf("%s_lane%0d", tag, i), 64'(out_data[i*ACC_W +: ACC_W]), 64'(ref_val(m_acc[i])));
      if (m_en[i] && ref_clip(m_acc[i])) any_clip = 1'b1;
    end
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(any_clip));
    chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_take_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_take_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a_data = '0; b_data = '0; lane_en = '1; out_ready = 1'b0;
    m_open = 1'b0; m_mode = 1'b0;
    for (int i = 0; i < N_LANE; i++) begin m_acc[i] = 0; m_en[i] = 1'b1; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_data_zero", 64'(out_data != '0), 64'd0);

    // broadcast: a lane0 = 2, b = 3, three beats -> 18 everywhere
    fill_rand();
    mode = 1'b0; lane_en = '1;
    a_data[0 +: A_W] = A_W'(2);
    for (int i = 0; i < N_LANE; i++) b_data[i*B_W +: B_W] = B_W'(3);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    chk("bcast_model_18", 64'(m_acc[100]), 64'd18);
    expect_result("bcast");
    take("bcast");

    // groups: group k = k+1, b = 1, single first+last beat
    mode = 1'b1;
    for (int k = 0; k < G; k++) a_data[k*A_W +: A_W] = A_W'(k + 1);
    for (int i = 0; i < N_LANE; i++) b_data[i*B_W +: B_W] = B_W'(1);
    send(1'b1, 1'b1);
    chk("group_model_lane13", 64'(m_acc[13]), 64'd2);
    expect_result("group");

    // backpressure: hold result for 5 cycles
    snap = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", 64'(out_data == snap), 64'd1);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    take("bp");

    // saturation / wrap: 4 beats of 32767 * 127
    mode = 1'b0;
    fill(32767, 127);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    expect_result("sat");
    take("sat");

    // lane mask: lane 5 disabled, a = b = 1
    fill(1, 1);
    lane_en = '1; lane_en[5] = 1'b0;
    send(1'b1, 1'b1);
    lane_en = '1;
    expect_result("mask");
    chk("mask_lane5_zero", 64'(out_data[5*ACC_W +: ACC_W]), 64'd0);
    take("mask");

    // reset in the middle of a 4-beat sum
    fill_rand();
    send(1'b1, 1'b0);
    fill_rand();
    send(1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_open = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    fill(1, 1);
    mode = 1'b0;
    send(1'b1, 1'b1);
    expect_result("after_rst");
    chk("after_rst_lane0", 64'(out_data[0 +: ACC_W]), 64'd1);
    take("after_rst");

    // randomized sums: mode, mask, data, gaps, implicit first
    for (int s = 0; s < 8; s++) begin
      int nb = int'($urandom_range(1, 4));
      mode = 1'($urandom);
      for (int i = 0; i < N_LANE; i++) lane_en[i] = ($urandom_range(0, 7) != 0);
      for (int bt = 0; bt < nb; bt++) begin
        fill_rand();
        send((bt == 0) ? 1'($urandom) : 1'b0, bt == nb - 1);
        mode = 1'($urandom);
        for (int i = 0; i < N_LANE; i++) lane_en[i] = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      // random trailing gaps above may have consumed the T+1 slot; re-check from scratch
      if (!out_valid) begin
        int n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      end
      chk($sformatf("rnd%0d_valid", s), 64'(out_valid), 64'd1);
      begin
        bit any_clip = 1'b0;
        for (int i = 0; i < N_LANE; i++) begin
          chk($sformatf("rnd%0d_lane%0d", s, i), 64'(out_data[i*ACC_W +: ACC_W]), 64'(ref_val(m_acc[i])));
          if (m_en[i] && ref_clip(m_acc[i])) any_clip = 1'b1;
        end
        chk($sformatf("rnd%0d_ovf", s), 64'(out_ovf), 64'(any_clip));
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      take($sformatf("rnd%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
